// File: rtl/e203_subsys_irq_cond_if.sv
// ICB slave port bundle for the interrupt conditioner configuration registers.
interface e203_subsys_irq_cond_if #(
    parameter int AW = 12
);
    logic          icb_cmd_valid;
    logic          icb_cmd_ready;
    logic [AW-1:0] icb_cmd_addr;
    logic          icb_cmd_read;
    logic [31:0]   icb_cmd_wdata;
    logic [3:0]    icb_cmd_wmask;
    logic          icb_rsp_valid;
    logic          icb_rsp_ready;
    logic          icb_rsp_err;
    logic [31:0]   icb_rsp_rdata;

    modport master (
        output icb_cmd_valid, icb_cmd_addr, icb_cmd_read, icb_cmd_wdata, icb_cmd_wmask, icb_rsp_ready,
        input  icb_cmd_ready, icb_rsp_valid, icb_rsp_err, icb_rsp_rdata
    );

    modport slave (
        input  icb_cmd_valid, icb_cmd_addr, icb_cmd_read, icb_cmd_wdata, icb_cmd_wmask, icb_rsp_ready,
        output icb_cmd_ready, icb_rsp_valid, icb_rsp_err, icb_rsp_rdata
    );
endinterface

// File: rtl/e203_subsys_irq_cond.sv
// Interrupt conditioner: synchronizes raw peripheral IRQs, applies polarity,
// edge/level selection with W1C pending latches and a forward mask before the PLIC.
module e203_subsys_irq_cond #(
    parameter int NUM_IRQ = 16,
    parameter int SYNC_DP = 2,
    parameter int AW      = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    e203_subsys_irq_cond_if.slave icb,
    input  logic [NUM_IRQ-1:0]   irq_in,
    output logic [NUM_IRQ-1:0]   irq_out
);

    logic [NUM_IRQ-1:0] sync_q [SYNC_DP];
    logic [NUM_IRQ-1:0] sync_d [SYNC_DP];
    logic [NUM_IRQ-1:0] prev_q, prev_d;
    logic [NUM_IRQ-1:0] mode_q, mode_d;
    logic [NUM_IRQ-1:0] pol_q, pol_d;
    logic [NUM_IRQ-1:0] pend_q, pend_d;
    logic [NUM_IRQ-1:0] mask_q, mask_d;
    logic [NUM_IRQ-1:0] irq_out_q, irq_out_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               rsp_err_q, rsp_err_d;
    logic [31:0]        rsp_rdata_q, rsp_rdata_d;

    logic [NUM_IRQ-1:0] raw, s, rise, wen, wbits, pend_clr;
    logic [AW-3:0]      word;
    logic               cmd_hs, wr_en;
    logic               sel_mode, sel_pol, sel_pend, sel_mask, sel_raw, hit;
    logic               unused_bits;

    // Per-bit byte enable: bit i is writable when its byte lane is enabled.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_IRQ; gi++) begin : g_wen
            assign wen[gi] = icb.icb_cmd_wmask[gi/8];
        end
    endgenerate

    assign unused_bits = ^{icb.icb_cmd_addr[1:0], icb.icb_cmd_wdata, icb.icb_cmd_wmask};

    assign raw   = sync_q[SYNC_DP-1];
    assign s     = raw ^ pol_q;
    assign rise  = s & ~prev_q;
    assign wbits = icb.icb_cmd_wdata[NUM_IRQ-1:0];
    assign word  = icb.icb_cmd_addr[AW-1:2];

    assign sel_mode = (word == (AW-2)'(0));
    assign sel_pol  = (word == (AW-2)'(1));
    assign sel_pend = (word == (AW-2)'(2));
    assign sel_mask = (word == (AW-2)'(3));
    assign sel_raw  = (word == (AW-2)'(4));
    assign hit      = sel_mode | sel_pol | sel_pend | sel_mask | sel_raw;

    assign icb.icb_cmd_ready = ~rsp_valid_q | icb.icb_rsp_ready;
    assign cmd_hs            = icb.icb_cmd_valid & icb.icb_cmd_ready;
    assign wr_en             = cmd_hs & ~icb.icb_cmd_read;

    always_comb begin
        sync_d[0] = irq_in;
        for (int i = 1; i < SYNC_DP; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        prev_d = s;
        mode_d = mode_q;
        pol_d  = pol_q;
        mask_d = mask_q;
        if (wr_en && sel_mode) mode_d = (mode_q & ~wen) | (wbits & wen);
        if (wr_en && sel_pol)  pol_d  = (pol_q  & ~wen) | (wbits & wen);
        if (wr_en && sel_mask) mask_d = (mask_q & ~wen) | (wbits & wen);
        pend_clr = (wr_en && sel_pend) ? (wbits & wen) : '0;
        // Set dominates clear; level-mode sources never hold a pending bit.
        pend_d    = mode_q & ((pend_q & ~pend_clr) | rise);
        irq_out_d = mask_q & ((mode_q & pend_q) | (~mode_q & s));

        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        if (cmd_hs) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = ~hit | (~icb.icb_cmd_read & sel_raw);
            rsp_rdata_d = '0;
            if (icb.icb_cmd_read) begin
                unique case (1'b1)
                    sel_mode: rsp_rdata_d = 32'(mode_q);
                    sel_pol:  rsp_rdata_d = 32'(pol_q);
                    sel_pend: rsp_rdata_d = 32'(pend_q);
                    sel_mask: rsp_rdata_d = 32'(mask_q);
                    sel_raw:  rsp_rdata_d = 32'(raw);
                    default:  rsp_rdata_d = '0;
                endcase
            end
        end else if (icb.icb_rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_DP; i++) begin
                sync_q[i] <= '0;
            end
            prev_q      <= '0;
            mode_q      <= '0;
            pol_q       <= '0;
            pend_q      <= '0;
            mask_q      <= '1;
            irq_out_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            for (int i = 0; i < SYNC_DP; i++) begin
                sync_q[i] <= sync_d[i];
            end
            prev_q      <= prev_d;
            mode_q      <= mode_d;
            pol_q       <= pol_d;
            pend_q      <= pend_d;
            mask_q      <= mask_d;
            irq_out_q   <= irq_out_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign irq_out           = irq_out_q;
    assign icb.icb_rsp_valid = rsp_valid_q;
    assign icb.icb_rsp_err   = rsp_err_q;
    assign icb.icb_rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_e203_subsys_irq_cond.sv
// Directed self-checking bench for e203_subsys_irq_cond (NUM_IRQ=16, SYNC_DP=2, AW=12).
module tb_e203_subsys_irq_cond;

    logic        clk;
    logic        rst_n;
    logic [15:0] irq_in;
    logic [15:0] irq_out;
    int          passed;
    int          total;
    logic [31:0] rd;
    logic        er;

    e203_subsys_irq_cond_if #(.AW(12)) icb ();

    e203_subsys_irq_cond #(.NUM_IRQ(16), .SYNC_DP(2), .AW(12)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .icb     (icb.slave),
        .irq_in  (irq_in),
        .irq_out (irq_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Issue one ICB command; returns just after the response edge with rsp_ready held high.
    task automatic xfer(input logic is_rd, input logic [11:0] addr, input logic [31:0] wd,
                        input logic [3:0] wm, output logic [31:0] rdata, output logic err);
        int w;
        icb.icb_cmd_valid = 1'b1;
        icb.icb_cmd_read  = is_rd;
        icb.icb_cmd_addr  = addr;
        icb.icb_cmd_wdata = wd;
        icb.icb_cmd_wmask = wm;
        w = 0;
        while (icb.icb_cmd_ready !== 1'b1 && w < 20) begin
            step(1);
            w++;
        end
        if (w >= 20) begin
            total++;
            $display("FAIL xfer_timeout: cmd_ready got %b required 1", icb.icb_cmd_ready);
        end
        @(posedge clk);
        #1;
        icb.icb_cmd_valid = 1'b0;
        rdata = icb.icb_rsp_rdata;
        err   = icb.icb_rsp_err;
        $display("icb %s addr=%h wdata=%h wmask=%h -> rdata=%h err=%b",
                 is_rd ? "RD" : "WR", addr, wd, wm, rdata, err);
    endtask

    task automatic test_reset();
        xfer(1, 12'h000, 0, 4'hF, rd, er);
        total++; if (rd !== 32'h0) $display("FAIL rst_mode got=%h req=%h", rd, 32'h0); else passed++;
        xfer(1, 12'h004, 0, 4'hF, rd, er);
        total++; if (rd !== 32'h0) $display("FAIL rst_pol got=%h req=%h", rd, 32'h0); else passed++;
        xfer(1, 12'h008, 0, 4'hF, rd, er);
        total++; if (rd !== 32'h0) $display("FAIL rst_pend got=%h req=%h", rd, 32'h0); else passed++;
        xfer(1, 12'h00C, 0, 4'hF, rd, er);
        total++; if (rd !== 32'h0000FFFF) $display("FAIL rst_mask got=%h req=%h", rd, 32'h0000FFFF); else passed++;
        xfer(1, 12'h010, 0, 4'hF, rd, er);
        total++; if (rd !== 32'h0 || er !== 1'b0) $display("FAIL rst_raw got=%h/%b req=0/0", rd, er); else passed++;
        total++; if (irq_out !== 16'h0) $display("FAIL rst_irq_out got=%h req=%h", irq_out, 16'h0); else passed++;
        irq_in[3] = 1'b1;
        step(2);
        total++; if (irq_out[3] !== 1'b0) $display("FAIL lvl_lat_early got=%b req=0", irq_out[3]); else passed++;
        step(1);
        total++; if (irq_out[3] !== 1'b1) $display("FAIL lvl_lat_3 got=%b req=1", irq_out[3]); else passed++;
        irq_in[3] = 1'b0;
        step(4);
        total++; if (irq_out !== 16'h0) $display("FAIL lvl_fall got=%h req=0", irq_out); else passed++;
    endtask

    task automatic test_level_pol();
        xfer(0, 12'h004, 32'h1, 4'hF, rd, er);
        step(3);
        total++; if (irq_out[0] !== 1'b1) $display("FAIL pol_invert got=%b req=1", irq_out[0]); else passed++;
        irq_in[0] = 1'b1;
        step(2);
        total++; if (irq_out[0] !== 1'b1) $display("FAIL pol_clr_early got=%b req=1", irq_out[0]); else passed++;
        step(1);
        total++; if (irq_out[0] !== 1'b0) $display("FAIL pol_clr_3 got=%b req=0", irq_out[0]); else passed++;
        xfer(0, 12'h004, 32'h0, 4'hF, rd, er);
        step(3);
        total++; if (irq_out[0] !== 1'b1) $display("FAIL pol_restore got=%b req=1", irq_out[0]); else passed++;
    endtask

    task automatic test_edge();
        xfer(0, 12'h000, 32'h20, 4'hF, rd, er);
        irq_in[5] = 1'b1;
        step(3);
        irq_in[5] = 1'b0;
        step(6);
        xfer(1, 12'h008, 0, 4'hF, rd, er);
        total++; if (rd !== 32'h20) $display("FAIL edge_pend got=%h req=%h", rd, 32'h20); else passed++;
        total++; if (irq_out[5] !== 1'b1) $display("FAIL edge_hold got=%b req=1", irq_out[5]); else passed++;
        xfer(0, 12'h008, 32'h20, 4'hF, rd, er);
        total++; if (irq_out[5] !== 1'b1) $display("FAIL w1c_same_edge got=%b req=1", irq_out[5]); else passed++;
        step(1);
        total++; if (irq_out[5] !== 1'b0) $display("FAIL w1c_out got=%b req=0", irq_out[5]); else passed++;
        xfer(1, 12'h008, 0, 4'hF, rd, er);
        total++; if (rd !== 32'h0) $display("FAIL w1c_pend got=%h req=0", rd); else passed++;
        irq_in[5] = 1'b1;
        step(3);
        irq_in[5] = 1'b0;
        step(6);
        total++; if (irq_out[5] !== 1'b1) $display("FAIL edge_again got=%b req=1", irq_out[5]); else passed++;
        // Rise lands on the same edge that accepts the W1C.
        irq_in[5] = 1'b1;
        step(2);
        xfer(0, 12'h008, 32'h20, 4'hF, rd, er);
        xfer(1, 12'h008, 0, 4'hF, rd, er);
        total++; if (rd !== 32'h20) $display("FAIL set_wins got=%h req=%h", rd, 32'h20); else passed++;
        irq_in[5] = 1'b0;
        xfer(0, 12'h008, 32'h20, 4'hF, rd, er);
        xfer(0, 12'h000, 32'h0, 4'hF, rd, er);
        step(4);
        total++; if (irq_out !== 16'h0001) $display("FAIL edge_cleanup got=%h req=%h", irq_out, 16'h0001); else passed++;
    endtask

    task automatic test_mask();
        xfer(0, 12'h00C, 32'hFFFE, 4'hF, rd, er);
        step(2);
        total++; if (irq_out[0] !== 1'b0) $display("FAIL mask_off got=%b req=0", irq_out[0]); else passed++;
        xfer(1, 12'h010, 0, 4'hF, rd, er);
        total++; if (rd !== 32'h1) $display("FAIL mask_raw got=%h req=%h", rd, 32'h1); else passed++;
        xfer(0, 12'h00C, 32'hFFFF, 4'hF, rd, er);
        total++; if (irq_out[0] !== 1'b0) $display("FAIL unmask_early got=%b req=0", irq_out[0]); else passed++;
        step(1);
        total++; if (irq_out[0] !== 1'b1) $display("FAIL unmask got=%b req=1", irq_out[0]); else passed++;
    endtask

    task automatic test_backpressure();
        icb.icb_rsp_ready = 1'b0;
        icb.icb_cmd_valid = 1'b1;
        icb.icb_cmd_read  = 1'b1;
        icb.icb_cmd_addr  = 12'h00C;
        step(1);
        icb.icb_cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (icb.icb_rsp_valid !== 1'b1 || icb.icb_cmd_ready !== 1'b0 || icb.icb_rsp_rdata !== 32'hFFFF)
                $display("FAIL stall_%0d got v=%b rdy=%b rdata=%h req v=1 rdy=0 rdata=0000ffff",
                         i, icb.icb_rsp_valid, icb.icb_cmd_ready, icb.icb_rsp_rdata);
            else passed++;
            step(1);
        end
        icb.icb_rsp_ready = 1'b1;
        #1;
        total++; if (icb.icb_cmd_ready !== 1'b1) $display("FAIL stall_release got=%b req=1", icb.icb_cmd_ready); else passed++;
        step(1);
        total++; if (icb.icb_rsp_valid !== 1'b0) $display("FAIL rsp_drop got=%b req=0", icb.icb_rsp_valid); else passed++;
    endtask

    task automatic test_errors();
        xfer(1, 12'h014, 0, 4'hF, rd, er);
        total++; if (er !== 1'b1 || rd !== 32'h0) $display("FAIL bad_read got=%h/%b req=0/1", rd, er); else passed++;
        xfer(0, 12'h010, 32'hFFFF, 4'hF, rd, er);
        total++; if (er !== 1'b1) $display("FAIL raw_write_err got=%b req=1", er); else passed++;
        xfer(1, 12'h010, 0, 4'hF, rd, er);
        total++; if (rd !== 32'h1 || er !== 1'b0) $display("FAIL raw_intact got=%h/%b req=1/0", rd, er); else passed++;
        xfer(0, 12'h000, 32'hFFFF, 4'h2, rd, er);
        xfer(1, 12'h000, 0, 4'hF, rd, er);
        total++; if (rd !== 32'hFF00) $display("FAIL wmask_mode got=%h req=%h", rd, 32'hFF00); else passed++;
        xfer(0, 12'h000, 32'h0, 4'hF, rd, er);
        xfer(0, 12'h00C, 32'hFFFF_FFFF, 4'hF, rd, er);
        xfer(1, 12'h00C, 0, 4'hF, rd, er);
        total++; if (rd !== 32'hFFFF) $display("FAIL upper_bits got=%h req=%h", rd, 32'hFFFF); else passed++;
    endtask

    task automatic test_async_reset();
        irq_in = 16'h0;
        step(4);
        xfer(0, 12'h000, 32'hFF, 4'hF, rd, er);
        xfer(0, 12'h004, 32'hFF, 4'hF, rd, er);
        step(3);
        xfer(1, 12'h008, 0, 4'hF, rd, er);
        total++; if (rd !== 32'hFF) $display("FAIL pend_ff got=%h req=%h", rd, 32'hFF); else passed++;
        total++; if (irq_out !== 16'h00FF) $display("FAIL out_ff got=%h req=%h", irq_out, 16'h00FF); else passed++;
        xfer(0, 12'h00C, 32'hF0, 4'hF, rd, er);
        step(1);
        total++; if (irq_out !== 16'h00F0) $display("FAIL out_masked got=%h req=%h", irq_out, 16'h00F0); else passed++;
        icb.icb_rsp_ready = 1'b0;
        icb.icb_cmd_valid = 1'b1;
        icb.icb_cmd_read  = 1'b1;
        icb.icb_cmd_addr  = 12'h008;
        step(1);
        icb.icb_cmd_valid = 1'b0;
        total++; if (icb.icb_rsp_valid !== 1'b1) $display("FAIL pre_rst_valid got=%b req=1", icb.icb_rsp_valid); else passed++;
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (irq_out !== 16'h0) $display("FAIL async_out got=%h req=0", irq_out); else passed++;
        total++; if (icb.icb_rsp_valid !== 1'b0 || icb.icb_rsp_rdata !== 32'h0)
            $display("FAIL async_rsp got=%b/%h req=0/0", icb.icb_rsp_valid, icb.icb_rsp_rdata); else passed++;
        icb.icb_rsp_ready = 1'b1;
        step(2);
        rst_n = 1'b1;
        step(1);
        xfer(1, 12'h008, 0, 4'hF, rd, er);
        total++; if (rd !== 32'h0) $display("FAIL post_rst_pend got=%h req=0", rd); else passed++;
        xfer(1, 12'h00C, 0, 4'hF, rd, er);
        total++; if (rd !== 32'hFFFF) $display("FAIL post_rst_mask got=%h req=%h", rd, 32'hFFFF); else passed++;
        xfer(1, 12'h004, 0, 4'hF, rd, er);
        total++; if (rd !== 32'h0) $display("FAIL post_rst_pol got=%h req=0", rd); else passed++;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        rst_n  = 1'b0;
        irq_in = 16'h0;
        icb.icb_cmd_valid = 1'b0;
        icb.icb_cmd_read  = 1'b0;
        icb.icb_cmd_addr  = '0;
        icb.icb_cmd_wdata = '0;
        icb.icb_cmd_wmask = '0;
        icb.icb_rsp_ready = 1'b1;
        step(3);
        rst_n = 1'b1;
        test_reset();
        test_level_pol();
        test_edge();
        test_mask();
        test_backpressure();
        test_errors();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
